conv_result_buffer: RTL and testbench

CONV_RESULT_BUFFER -- requirements
Module: conv_result_buffer

---
 rtl/conv_result_buffer.sv | 139 +++++++++++++
 tb/tb_conv_result_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/conv_result_buffer.sv
// Collects one frame of convolution results and drains it in arrival (row-major) order.
// Optional define CONV_RESULT_RELU_EN clamps negative words to zero as they are stored.
//
// state | meaning
// FILL  | accepting words from the upstream stage into mem
// DRAIN | presenting stored words on m_* until the last is taken
module conv_result_buffer #(
  parameter int N = 3,
  parameter int M = 2,
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_end,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         m_last,
  output logic [5:0]   m_row,
  output logic [5:0]   m_col,
  output logic         busy,
  output logic         drop,
  output logic         short_frame
);

  localparam int OS    = N - M + 1;
  localparam int CAP   = OS * OS;
  localparam int AW    = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [5:0] CAP_C   = 6'(CAP);
  localparam logic [5:0] OS_LAST = 6'(OS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] wr_word;
  logic [5:0]   wr_cnt;
  logic [5:0]   rd_ptr;
  logic [5:0]   frame_len;
  logic [5:0]   cnt_after;
  logic         fill_wr;
  logic         go_drain;
  logic         xfer;
  logic         done;

`ifdef CONV_RESULT_RELU_EN
  assign wr_word = in_data[W-1] ? '0 : in_data;
`else
  assign wr_word = in_data;
`endif

  // cnt_after counts a word written in the same cycle as in_end
  assign fill_wr   = (state == FILL) && in_valid && (wr_cnt < CAP_C);
  assign cnt_after = wr_cnt + {5'd0, fill_wr};
  assign go_drain  = (state == FILL) && in_end && (cnt_after != 6'd0);
  assign xfer      = m_valid && m_ready;
  assign done      = xfer && m_last;

  always_ff @(posedge clock) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (go_drain) state_nxt = DRAIN;
      DRAIN:   if (done)     state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    m_valid = 1'b0;
    busy    = 1'b0;
    m_last  = 1'b0;
    if (state == DRAIN) begin
      m_valid = 1'b1;
      busy    = 1'b1;
      m_last  = (rd_ptr == frame_len - 6'd1);
    end
  end

  always_ff @(posedge clock) begin
    if (fill_wr) mem[wr_cnt[AW-1:0]] <= wr_word;
  end

  assign m_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      frame_len   <= '0;
      m_row       <= '0;
      m_col       <= '0;
      drop        <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fill_wr) wr_cnt <= cnt_after;
          if (in_valid && !fill_wr) drop <= 1'b1;
          if (go_drain) begin
            rd_ptr      <= '0;
            frame_len   <= cnt_after;
            short_frame <= (cnt_after < CAP_C);
          end
        end
        DRAIN: begin
          if (in_valid) drop <= 1'b1;
          // end of frame clears everything, overriding a drop seen this cycle
          if (done) begin
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            m_row       <= '0;
            m_col       <= '0;
            drop        <= 1'b0;
            short_frame <= 1'b0;
          end else if (xfer) begin
            rd_ptr <= rd_ptr + 6'd1;
            if (m_col == OS_LAST) begin
              m_col <= '0;
              m_row <= m_row + 6'd1;
            end else begin
              m_col <= m_col + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_result_buffer.sv
// Bench for conv_result_buffer: directed frames followed by random traffic,
// compared every cycle against a queue-based model of a frame.
module tb_conv_result_buffer;

  localparam int N   = 3;
  localparam int M   = 2;
  localparam int W   = 32;
  localparam int OS  = N - M + 1;
  localparam int CAP = OS * OS;

  logic         clock = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_end = 1'b0;
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [5:0]   m_row;
  logic [5:0]   m_col;
  logic         busy;
  logic         drop;
  logic         short_frame;

  int n_checks = 0;
  int n_err = 0;

  // model: stored words, whether draining, index of word on offer, flags
  logic [W-1:0] q[$];
  bit           draining = 0;
  int           k = 0;
  bit           mdrop = 0;
  bit           mshort = 0;

  conv_result_buffer #(.N(N), .M(M), .W(W)) dut (
    .clock(clock), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_end(in_end), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_row(m_row), .m_col(m_col), .busy(busy),
    .drop(drop), .short_frame(short_frame)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef CONV_RESULT_RELU_EN
    return d[W-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  // check outputs, then drive inputs for the next rising edge and advance the model
  task automatic step(input logic v, input logic [W-1:0] d, input logic e, input logic r);
    @(negedge clock);
    chk("m_valid", W'(m_valid), W'(draining));
    chk("busy", W'(busy), W'(draining));
    chk("drop", W'(drop), W'(mdrop));
    chk("short_frame", W'(short_frame), W'(mshort));
    chk("m_last", W'(m_last), W'(draining && (k == q.size() - 1)));
    chk("m_row", W'(m_row), W'(k / OS));
    chk("m_col", W'(m_col), W'(k % OS));
    if (draining) chk("m_data", m_data, q[k]);
    rst = 1'b0;
    in_valid = v;
    in_data = d;
    in_end = e;
    m_ready = r;
    if (!draining) begin
      if (v) begin
        if (q.size() < CAP) q.push_back(stored(d));
        else mdrop = 1;
      end
      if (e && q.size() > 0) begin
        draining = 1;
        k = 0;
        mshort = (q.size() < CAP);
      end
    end else begin
      if (v) mdrop = 1;
      if (r) begin
        if (k == q.size() - 1) begin
          draining = 0;
          q.delete();
          k = 0;
          mdrop = 0;
          mshort = 0;
        end else begin
          k++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    in_valid = 1'b0;
    in_end = 1'b0;
    m_ready = 1'b0;
    q.delete();
    draining = 0;
    k = 0;
    mdrop = 0;
    mshort = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int pat[7];
    do_reset();
    idle(2);

    // basic frame 5,-2,7,9 then in_end, drained with ready held high
    step(1'b1, 32'd5, 1'b0, 1'b1);
    step(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
    step(1'b1, 32'd7, 1'b0, 1'b1);
    step(1'b1, 32'd9, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // in_end on an empty buffer is ignored
    step(1'b0, '0, 1'b1, 1'b1);
    idle(2);

    // stalled drain with ready pattern 1,0,0,1,1,0,1
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 4; i++) step(1'b1, 32'(100 + i), (i == 3), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, pat[i][0]);
    idle(2);

    // five words into a four-word buffer sets drop until the frame ends
    for (int i = 0; i < 5; i++) step(1'b1, 32'(200 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // short frame: end coincides with the second word
    step(1'b1, 32'd300, 1'b0, 1'b1);
    step(1'b1, 32'd301, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd999, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    // reset after the second transfer abandons the frame; next frame is clean
    for (int i = 0; i < 4; i++) step(1'b1, 32'(400 + i), (i == 3), 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0000 | 32'(500 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b1);

    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 6) == 0,
           $urandom_range(0, 2) != 0);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
